// File: rtl/alu_txn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_txn_sequencer_if
// Brief    : Request, ALU-issue and response signal bundle of the sequencer.
// Revision : 1.0
// ============================================================================
interface alu_txn_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 7,
    parameter int TAG_W  = 4
);
    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]          req_valid_i;
    logic [NUM_CH-1:0]          req_ready_o;
    logic [NUM_CH*OP_W-1:0]     req_op_i;
    logic [NUM_CH*3*DATA_W-1:0] req_operands_i;

    logic                       alu_enable_o;
    logic [OP_W-1:0]            alu_operator_o;
    logic [DATA_W-1:0]          alu_operand_a_o;
    logic [DATA_W-1:0]          alu_operand_b_o;
    logic [DATA_W-1:0]          alu_operand_c_o;
    logic                       alu_ex_ready_o;
    logic [DATA_W-1:0]          alu_result_i;
    logic                       alu_comparison_i;
    logic                       alu_ready_i;

    logic                       rsp_valid_o;
    logic                       rsp_ready_i;
    logic [c_CH_W-1:0]          rsp_ch_o;
    logic [TAG_W-1:0]           rsp_tag_o;
    logic [DATA_W-1:0]          rsp_result_o;
    logic                       rsp_cmp_o;
    logic                       rsp_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_operands_i,
        output req_ready_o,
        output alu_enable_o, alu_operator_o, alu_operand_a_o, alu_operand_b_o,
        output alu_operand_c_o, alu_ex_ready_o,
        input  alu_result_i, alu_comparison_i, alu_ready_i,
        output rsp_valid_o, rsp_ch_o, rsp_tag_o, rsp_result_o, rsp_cmp_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_op_i, req_operands_i,
        input  req_ready_o,
        input  alu_enable_o, alu_operator_o, alu_operand_a_o, alu_operand_b_o,
        input  alu_operand_c_o, alu_ex_ready_o,
        output alu_result_i, alu_comparison_i, alu_ready_i,
        input  rsp_valid_o, rsp_ch_o, rsp_tag_o, rsp_result_o, rsp_cmp_o, rsp_err_o,
        output rsp_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/alu_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_txn_sequencer
// Brief    : Round-robin multi-channel ALU issue front end with response FIFO
//            and per-operation timeout.
// Revision : 1.0
// ============================================================================
module alu_txn_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 7,
    parameter int DEPTH     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_txn_sequencer_if.slave       bus,
    output logic                     busy_o,
    output logic                     err_timeout_o
);
    localparam int c_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_RPTR_W = $clog2(RSP_DEPTH);
    localparam int c_CNT_W  = $clog2(TIMEOUT) + 1;
    localparam int c_RSP_W  = c_CH_W + TAG_W + DATA_W + 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    state_e              r_state, w_state_nxt;

    logic [NUM_CH-1:0]   w_full, w_empty, w_push, w_pop;
    logic [OP_W-1:0]     w_head_op   [NUM_CH];
    logic [3*DATA_W-1:0] w_head_opnd [NUM_CH];
    logic [TAG_W-1:0]    w_head_tag  [NUM_CH];

    logic                w_grant_vld;
    logic [c_CH_W-1:0]   w_grant_ch, w_scan;
    logic                w_issue, w_rsp_push, w_abort, w_cnt_inc, w_exec;

    logic [c_CH_W-1:0]   r_rr, r_ch;
    logic [OP_W-1:0]     r_op;
    logic [3*DATA_W-1:0] r_opnd;
    logic [TAG_W-1:0]    r_tag;
    logic [c_CNT_W-1:0]  r_tmo_cnt;
    logic                r_err_tmo;

    logic [c_RSP_W-1:0]  r_rsp_mem [RSP_DEPTH];
    logic [c_RPTR_W:0]   r_rsp_wr, r_rsp_rd;
    logic                w_rsp_full, w_rsp_empty, w_rsp_pop;
    logic [DATA_W-1:0]   w_rsp_res;
    logic                w_rsp_cmp;

    // Per-channel request FIFOs; each entry carries the tag assigned at accept
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [OP_W-1:0]     r_mem_op   [DEPTH];
        logic [3*DATA_W-1:0] r_mem_opnd [DEPTH];
        logic [TAG_W-1:0]    r_mem_tag  [DEPTH];
        logic [c_PTR_W:0]    r_wr_ptr, r_rd_ptr;
        logic [TAG_W-1:0]    r_tag_cnt;

        assign w_empty[k] = (r_wr_ptr == r_rd_ptr);
        assign w_full[k]  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                            (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
        assign w_push[k]  = bus.req_valid_i[k] && !w_full[k];

        assign w_head_op[k]   = r_mem_op[r_rd_ptr[c_PTR_W-1:0]];
        assign w_head_opnd[k] = r_mem_opnd[r_rd_ptr[c_PTR_W-1:0]];
        assign w_head_tag[k]  = r_mem_tag[r_rd_ptr[c_PTR_W-1:0]];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_tag_cnt <= '0;
            end else begin
                if (w_push[k]) begin
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                    r_tag_cnt <= r_tag_cnt + 1'b1;
                end
                if (w_pop[k]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[k]) begin
                r_mem_op[r_wr_ptr[c_PTR_W-1:0]]   <= bus.req_op_i[k*OP_W +: OP_W];
                r_mem_opnd[r_wr_ptr[c_PTR_W-1:0]] <= bus.req_operands_i[k*3*DATA_W +: 3*DATA_W];
                r_mem_tag[r_wr_ptr[c_PTR_W-1:0]]  <= r_tag_cnt;
            end
        end
    end

    assign bus.req_ready_o = ~w_full;

    // Scan from the channel after the last grant, wrapping at NUM_CH
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_scan      = r_rr;
        for (int i = 0; i < NUM_CH; i++) begin
            w_scan = (w_scan == c_CH_W'(NUM_CH - 1)) ? '0 : w_scan + 1'b1;
            if (!w_grant_vld && !w_empty[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_scan;
            end
        end
    end

    assign w_exec             = (r_state == S_EXEC);
    assign bus.alu_ex_ready_o = w_exec && !w_rsp_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        w_issue     = 1'b0;
        w_rsp_push  = 1'b0;
        w_abort     = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_issue     = 1'b1;
                    w_pop       = NUM_CH'(1) << w_grant_ch;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // Nothing advances while the response FIFO is full, so an
                // abort push can never be lost
                if (bus.alu_ex_ready_o) begin
                    if (bus.alu_ready_i) begin
                        w_rsp_push  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_tmo_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        w_rsp_push  = 1'b1;
                        w_abort     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr      <= c_CH_W'(NUM_CH - 1);
            r_ch      <= '0;
            r_op      <= '0;
            r_opnd    <= '0;
            r_tag     <= '0;
            r_tmo_cnt <= '0;
            r_err_tmo <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rr      <= w_grant_ch;
                r_ch      <= w_grant_ch;
                r_op      <= w_head_op[w_grant_ch];
                r_opnd    <= w_head_opnd[w_grant_ch];
                r_tag     <= w_head_tag[w_grant_ch];
                r_tmo_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_abort) begin
                r_err_tmo <= 1'b1;
            end
        end
    end

    assign bus.alu_enable_o    = w_exec;
    assign bus.alu_operator_o  = w_exec ? r_op : '0;
    assign bus.alu_operand_a_o = w_exec ? r_opnd[0*DATA_W +: DATA_W] : '0;
    assign bus.alu_operand_b_o = w_exec ? r_opnd[1*DATA_W +: DATA_W] : '0;
    assign bus.alu_operand_c_o = w_exec ? r_opnd[2*DATA_W +: DATA_W] : '0;

    assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);
    assign w_rsp_full  = (r_rsp_wr[c_RPTR_W] != r_rsp_rd[c_RPTR_W]) &&
                         (r_rsp_wr[c_RPTR_W-1:0] == r_rsp_rd[c_RPTR_W-1:0]);
    assign w_rsp_pop   = !w_rsp_empty && bus.rsp_ready_i;
    assign w_rsp_res   = w_abort ? '0 : bus.alu_result_i;
    assign w_rsp_cmp   = w_abort ? 1'b0 : bus.alu_comparison_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_wr <= '0;
            r_rsp_rd <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_wr <= r_rsp_wr + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rsp_rd <= r_rsp_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wr[c_RPTR_W-1:0]] <= {r_ch, r_tag, w_rsp_res, w_rsp_cmp, w_abort};
        end
    end

    assign bus.rsp_valid_o = !w_rsp_empty;
    assign {bus.rsp_ch_o, bus.rsp_tag_o, bus.rsp_result_o, bus.rsp_cmp_o, bus.rsp_err_o} =
        r_rsp_mem[r_rsp_rd[c_RPTR_W-1:0]];

    assign busy_o        = w_exec || !(&w_empty) || !w_rsp_empty;
    assign err_timeout_o = r_err_tmo;
endmodule
`default_nettype wire

// File: tb/tb_alu_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_txn_sequencer
// Brief    : Scoreboard bench for alu_txn_sequencer with a latency-controlled
//            ALU responder.
// Revision : 1.0
// ============================================================================
module tb_alu_txn_sequencer;
    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 32;
    localparam int OP_W      = 7;
    localparam int DEPTH     = 4;
    localparam int RSP_DEPTH = 4;
    localparam int TAG_W     = 4;
    localparam int TIMEOUT   = 8;
    localparam int CH_W      = 2;

    localparam logic [OP_W-1:0] c_OP_ADD = 7'b0011000;
    localparam logic [OP_W-1:0] c_OP_SUB = 7'b0011001;
    localparam logic [OP_W-1:0] c_OP_XOR = 7'b0101111;
    localparam logic [OP_W-1:0] c_OP_DIV = 7'b0110101;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] res;
        logic              cmp;
        logic              err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_o, err_timeout_o;

    always #5 clk = ~clk;

    alu_txn_sequencer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W)) bus ();

    alu_txn_sequencer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH),
        .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [TAG_W-1:0] exp_tag [NUM_CH];

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            c_OP_ADD: return a + b;
            c_OP_SUB: return a - b;
            c_OP_XOR: return a ^ b;
            c_OP_DIV: return (b == '0) ? '1 : a / b;
            default:  return '0;
        endcase
    endfunction

    // ALU responder: ready after alu_lat cycles of enable
    int alu_lat = 0;
    int alu_cnt = 0;
    always @(posedge clk) alu_cnt <= bus.alu_enable_o ? alu_cnt + 1 : 0;
    assign bus.alu_ready_i      = bus.alu_enable_o && (alu_cnt >= alu_lat);
    assign bus.alu_result_i     = alu_fn(bus.alu_operator_o, bus.alu_operand_a_o, bus.alu_operand_b_o);
    assign bus.alu_comparison_i = bus.alu_operand_a_o < bus.alu_operand_b_o;

    int   n_rsp    = 0;
    int   en_cyc   = 0;
    int   stab_bad = 0;
    logic prev_en  = 1'b0;
    logic [OP_W+3*DATA_W-1:0] prev_issue = '0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                chk_eq("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk_eq("rsp_ch",     64'(bus.rsp_ch_o),     64'(e.ch));
                chk_eq("rsp_tag",    64'(bus.rsp_tag_o),    64'(e.tag));
                chk_eq("rsp_result", 64'(bus.rsp_result_o), 64'(e.res));
                chk_eq("rsp_cmp",    64'(bus.rsp_cmp_o),    64'(e.cmp));
                chk_eq("rsp_err",    64'(bus.rsp_err_o),    64'(e.err));
            end
        end
        if (bus.alu_enable_o) en_cyc++;
        if (bus.alu_enable_o && prev_en &&
            {bus.alu_operator_o, bus.alu_operand_c_o, bus.alu_operand_b_o, bus.alu_operand_a_o} != prev_issue)
            stab_bad++;
        prev_en    = bus.alu_enable_o;
        prev_issue = {bus.alu_operator_o, bus.alu_operand_c_o, bus.alu_operand_b_o, bus.alu_operand_a_o};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) exp_tag[c] = '0;
    endtask

    task automatic set_req(input int ch, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c, input bit exp_err);
        exp_t e;
        bus.req_valid_i[ch] = 1'b1;
        bus.req_op_i[ch*OP_W +: OP_W] = op;
        bus.req_operands_i[ch*3*DATA_W +: 3*DATA_W] = {c, b, a};
        e.ch  = CH_W'(ch);
        e.tag = exp_tag[ch];
        e.res = exp_err ? '0 : alu_fn(op, a, b);
        e.cmp = exp_err ? 1'b0 : (a < b);
        e.err = exp_err;
        exp_q.push_back(e);
        exp_tag[ch] = exp_tag[ch] + 1'b1;
    endtask

    task automatic push_req(input int ch, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c, input bit exp_err);
        int g = 0;
        while (!bus.req_ready_o[ch] && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 100) chk_eq("push_ready_wait", 64'(g), 64'd0);
        set_req(ch, op, a, b, c, exp_err);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid_i = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid_o) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int lat;
        bus.req_valid_i    = '0;
        bus.req_op_i       = '0;
        bus.req_operands_i = '0;
        bus.rsp_ready_i    = 1'b1;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_req_ready", 64'(bus.req_ready_o),    64'hF);
        chk_eq("rst_enable",    64'(bus.alu_enable_o),   64'd0);
        chk_eq("rst_operator",  64'(bus.alu_operator_o), 64'd0);
        chk_eq("rst_operand_a", 64'(bus.alu_operand_a_o), 64'd0);
        chk_eq("rst_ex_ready",  64'(bus.alu_ex_ready_o), 64'd0);
        chk_eq("rst_rsp_valid", 64'(bus.rsp_valid_o),    64'd0);
        chk_eq("rst_busy",      64'(busy_o),             64'd0);
        chk_eq("rst_err_tmo",   64'(err_timeout_o),      64'd0);
        rst = 1'b0;

        // Single ADD, latency from accept edge
        set_req(0, c_OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0);
        tick();
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid_o) begin
                lat = i;
                break;
            end
        end
        chk_eq("t1_latency", 64'(lat), 64'd2);
        wait_drain("t1_drain");
        chk_eq("t1_busy_idle", 64'(busy_o), 64'd0);

        // Four channels, two ops each, pushed together
        do_reset();
        n0 = n_rsp;
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                set_req(ch, (r == 0) ? c_OP_ADD : c_OP_SUB, DATA_W'(100 + ch*10 + r), DATA_W'(ch + 1),
                        DATA_W'(ch), 1'b0);
            tick();
        end
        wait_drain("t2_drain");
        chk_eq("t2_rsp_count", 64'(n_rsp - n0), 64'd8);

        // Multi-cycle DIV held while ready is low
        do_reset();
        alu_lat  = 5;
        en_cyc   = 0;
        stab_bad = 0;
        n0 = n_rsp;
        push_req(2, c_OP_DIV, 32'd100, 32'd7, 32'd3, 1'b0);
        wait_drain("t3_drain");
        chk_eq("t3_enable_cycles", 64'(en_cyc), 64'd6);
        chk_eq("t3_operand_stable", 64'(stab_bad), 64'd0);
        chk_eq("t3_rsp_count", 64'(n_rsp - n0), 64'd1);
        alu_lat = 0;

        // Response back-pressure
        do_reset();
        bus.rsp_ready_i = 1'b0;
        n0 = n_rsp;
        for (int i = 0; i < 5; i++)
            push_req(1, c_OP_XOR, DATA_W'(i*3 + 1), 32'h55, 32'd0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk_eq("t4_ex_ready_low", 64'(bus.alu_ex_ready_o), 64'd0);
        chk_eq("t4_held_in_exec", 64'(bus.alu_enable_o),   64'd1);
        chk_eq("t4_rsp_valid",    64'(bus.rsp_valid_o),    64'd1);
        chk_eq("t4_no_timeout",   64'(err_timeout_o),      64'd0);
        chk_eq("t4_no_pop",       64'(n_rsp - n0),         64'd0);
        bus.rsp_ready_i = 1'b1;
        wait_drain("t4_drain");
        chk_eq("t4_rsp_count", 64'(n_rsp - n0), 64'd5);

        // Timeout abort, then normal op on another channel
        do_reset();
        alu_lat = 1000;
        en_cyc  = 0;
        push_req(3, c_OP_ADD, 32'd1, 32'd2, 32'd0, 1'b1);
        wait_drain("t5_abort_drain");
        chk_eq("t5_abort_cycles", 64'(en_cyc), 64'd8);
        chk_eq("t5_err_set", 64'(err_timeout_o), 64'd1);
        alu_lat = 0;
        push_req(1, c_OP_ADD, 32'd9, 32'd9, 32'd0, 1'b0);
        wait_drain("t5_next_drain");
        chk_eq("t5_err_sticky", 64'(err_timeout_o), 64'd1);

        // Fill ch0, then reset mid-EXEC
        do_reset();
        alu_lat = 1000;
        for (int i = 0; i < 5; i++) begin
            set_req(0, c_OP_ADD, DATA_W'(i), 32'd1, 32'd0, 1'b0);
            tick();
        end
        chk_eq("t6_ch0_full", 64'(bus.req_ready_o[0]), 64'd0);
        chk_eq("t6_in_exec",  64'(bus.alu_enable_o),   64'd1);
        n0 = n_rsp;
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        chk_eq("t6_async_enable", 64'(bus.alu_enable_o), 64'd0);
        chk_eq("t6_async_ready",  64'(bus.req_ready_o),  64'hF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        alu_lat = 0;
        repeat (15) @(posedge clk);
        #1;
        chk_eq("t6_no_rsp", 64'(n_rsp - n0), 64'd0);
        push_req(0, c_OP_ADD, 32'd40, 32'd2, 32'd0, 1'b0);
        wait_drain("t6_drain");
        chk_eq("t6_busy_idle", 64'(busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_txn_sequencer.md
Name: alu_txn_sequencer

Overview:
- Multi-channel transaction front end for the cv32e40p ALU, used in the UVM environment and in standalone ALU harnesses.
- Buffers operation requests from NUM_CH independent requesters and arbitrates among them round-robin.
- Issues one operation at a time on the ALU enable/operator/operand/ex_ready signal set and holds it across multi-cycle operations (ready low).
- Returns results with channel ID and sequence tag through a response FIFO; a per-op timeout guards against hung operations.

Parameters:
NUM_CH, 4, number of requester channels (1..8)
DATA_W, 32, operand/result width
OP_W, 7, ALU operator width (alu_opcode_e)
DEPTH, 4, per-channel request FIFO depth (power of 2, >=2)
RSP_DEPTH, 4, response FIFO depth (power of 2, >=2)
TAG_W, 4, per-channel sequence tag width
TIMEOUT, 64, max EXEC cycles (counted only while alu_ex_ready_o=1) before abort

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid_i  in  NUM_CH  per-channel request valid
req_ready_o  out  NUM_CH  per-channel FIFO not full
req_op_i  in  NUM_CH*OP_W  packed operators, channel 0 in LSBs
req_operands_i  in  NUM_CH*3*DATA_W  packed {c,b,a} per channel
alu_enable_o  out  1  ALU enable
alu_operator_o  out  OP_W  ALU operator
alu_operand_a_o/b_o/c_o  out  DATA_W each  ALU operands
alu_ex_ready_o  out  1  downstream ready presented to ALU
alu_result_i  in  DATA_W  ALU result
alu_comparison_i  in  1  ALU comparison result
alu_ready_i  in  1  ALU operation complete
rsp_valid_o  out  1  response FIFO not empty
rsp_ready_i  in  1  response consumer ready
rsp_ch_o  out  $clog2(NUM_CH) (min 1)  originating channel
rsp_tag_o  out  TAG_W  sequence tag of the request
rsp_result_o  out  DATA_W  result (0 on timeout)
rsp_cmp_o  out  1  comparison result (0 on timeout)
rsp_err_o  out  1  response produced by timeout abort
busy_o  out  1  FSM in EXEC or any FIFO non-empty
err_timeout_o  out  1  sticky, set on any timeout; cleared only by rst

Behaviour:
- Reset: all FIFOs empty, tags 0, FSM IDLE, RR pointer = NUM_CH-1 (channel 0 wins first), timeout counter 0.
- Outputs during reset: req_ready_o all 1, alu_enable_o 0, operator/operands 0, alu_ex_ready_o 0, rsp_valid_o 0, busy_o 0, err_timeout_o 0.
- rst mid-operation drops alu_enable_o immediately (asynchronous). In-flight and queued transactions are discarded with no response.
- Request accept: push on req_valid_i[k] && req_ready_o[k]. req_ready_o[k] = !full[k] with no bypass: a full FIFO refuses even when popped the same cycle.
- Tag: the channel tag counter is stored with each accepted entry, then increments modulo 2^TAG_W.
- Arbitration: in IDLE, if any request FIFO is non-empty, grant the first non-empty channel starting at RR pointer+1 (wrapping). Pop it, register op/operands/ch/tag, set RR pointer = granted channel, go to EXEC.
- EXEC:
  - alu_enable_o = 1; operator/operands driven from registers and stable for the whole EXEC.
  - alu_ex_ready_o = !rsp_full, combinational.
  - Completion: alu_ready_i && alu_ex_ready_o. Push {ch, tag, result, cmp, err=0} to the response FIFO, go to IDLE.
  - No back-to-back issue: at least one IDLE cycle separates operations.
- Timeout:
  - Counter clears on entering EXEC and increments each EXEC cycle with alu_ex_ready_o=1 and no completion.
  - At counter == TIMEOUT-1 without completion: push {ch, tag, 0, 0, err=1}, set err_timeout_o, go to IDLE.
  - Frozen while the response FIFO is full, so an abort push always fits.
- Latency: accept at edge N; grant at edge N+1 when IDLE; enable high in cycle N+1..; single-cycle ALU op completes at edge N+2; rsp_valid_o high after edge N+2.
- Response FIFO: pop on rsp_valid_o && rsp_ready_i. Push and pop in the same cycle are legal, including when full (pop frees the slot, but alu_ex_ready_o already reflects full, so no push occurs).
- Ordering: responses leave in completion order, which equals issue order.
- Wrap-around: FIFO pointers use one extra bit for full/empty detection.

Test Plan:
- Reset, ch0 pushes ADD a=5 b=7, alu_ready_i tied 1 -> rsp after 3 edges: ch=0, tag=0, result=12, err=0; busy_o back to 0.
- ch0..ch3 each push 2 ops in the same cycle -> issue order ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3; tags 0,0,0,0,1,1,1,1.
- DIV on ch2 with alu_ready_i low 5 EXEC cycles -> alu_enable_o high 6 cycles, operands stable, exactly one response.
- rsp_ready_i=0, 5 single-cycle ops on ch1 (RSP_DEPTH=4) -> 4 responses queued, alu_ex_ready_o=0 with op 5 held in EXEC; raise rsp_ready_i -> op 5 completes, all 5 responses in order.
- TIMEOUT=8, alu_ready_i stuck 0 -> abort after 8 EXEC cycles, rsp_err_o=1, result 0, err_timeout_o sticky; next op on another channel completes normally.
- Fill ch0 with DEPTH entries -> req_ready_o[0]=0. Assert rst mid-EXEC -> alu_enable_o drops same cycle, no responses; after release, tags restart at 0.
